// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
//   SHA-256 message-schedule generator. It loads one 512-bit block as 16
//   big-endian 32-bit words, then streams the 64 (W[t], K[t], t) tuples to the
//   round stage, one per valid/ready handshake. A 16-word sliding window keeps
//   the most recent schedule words, and a 64-entry ROM holds the round constants.
// Ports
//   ACLK      : clock
//   ARST      : synchronous active-high reset; aborts any block in progress
//   IN_VALID  : IN_WORD valid
//   IN_READY  : block accepts a message word (LOAD only)
//   IN_WORD   : message word M[i], i = 0..15 in arrival order
//   OUT_VALID : OUT_W/OUT_K/OUT_T valid (RUN only)
//   OUT_READY : round stage consumes the current tuple
//   OUT_W     : W[t]
//   OUT_K     : K[t]
//   OUT_T     : round index t
//   OUT_LAST  : high with OUT_VALID when t == 63
//   BUSY      : high in RUN
module sha256_msg_sched (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_WORD,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_W,
  output logic [31:0] OUT_K,
  output logic [5:0]  OUT_T,
  output logic        OUT_LAST,
  output logic        BUSY
);

  typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [31:0] KROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [5:0]  t_r, t_s;
  logic [31:0] w_r [16];
  logic [31:0] w_new_s;
  logic        load_en_s, shift_en_s;
  logic        in_ready_r, in_ready_s;
  logic        out_valid_r, out_valid_s;
  logic        out_last_r, out_last_s;
  logic        busy_r, busy_s;
  logic [31:0] k_r, k_s;

  // Next-state logic; the registered outputs are derived from the next state so
  // that every output port comes straight from a flop.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    t_s        = t_r;
    load_en_s  = 1'b0;
    shift_en_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (IN_VALID && in_ready_r) begin
          load_en_s = 1'b1;
          if (cnt_r == 4'd15) begin
            state_s = ST_RUN;
            cnt_s   = 4'd0;
            t_s     = 6'd0;
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_RUN: begin
        if (out_valid_r && OUT_READY) begin
          shift_en_s = 1'b1;
          if (t_r == 6'd63) begin
            state_s = ST_LOAD;
            cnt_s   = 4'd0;
            t_s     = 6'd0;
          end else begin
            t_s = t_r + 6'd1;
          end
        end else begin
          t_s = t_r;
        end
      end
      default: begin
        state_s = ST_LOAD;
        cnt_s   = 4'd0;
        t_s     = 6'd0;
      end
    endcase
    in_ready_s  = (state_s == ST_LOAD);
    out_valid_s = (state_s == ST_RUN);
    busy_s      = (state_s == ST_RUN);
    out_last_s  = (state_s == ST_RUN) && (t_s == 6'd63);
    k_s         = KROM[t_s];
  end

  // Next schedule word; words appended after t = 47 are never emitted but the
  // update stays uniform to keep the datapath simple.
  always_comb begin
    w_new_s = sig1(w_r[14]) + w_r[9] + sig0(w_r[1]) + w_r[0];
  end

  // Control state and registered output flags.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_r     <= ST_LOAD;
      cnt_r       <= 4'd0;
      t_r         <= 6'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      k_r         <= KROM[0];
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      t_r         <= t_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      busy_r      <= busy_s;
      k_r         <= k_s;
    end
  end

  // Sliding window: filled by index during LOAD, shifted toward w[0] on each
  // RUN transfer so that w[0] is always the word being presented.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      for (int i = 0; i < 16; i++) begin
        w_r[i] <= 32'h00000000;
      end
    end else if (load_en_s) begin
      w_r[cnt_r] <= IN_WORD;
    end else if (shift_en_s) begin
      for (int i = 0; i < 15; i++) begin
        w_r[i] <= w_r[i+1];
      end
      w_r[15] <= w_new_s;
    end else begin
      for (int i = 0; i < 16; i++) begin
        w_r[i] <= w_r[i];
      end
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign OUT_W     = w_r[0];
  assign OUT_K     = k_r;
  assign OUT_T     = t_r;
  assign OUT_LAST  = out_last_r;
  assign BUSY      = busy_r;

endmodule
